// File: rtl/vc_test_rand_delay_ooo_tag_sink_if.sv
// Valid/ready message channel into the tag sink.
interface vc_test_rand_delay_ooo_tag_sink_if #(
  parameter int unsigned p_msg_nbits = 32
);
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/vc_test_rand_delay_ooo_tag_sink.sv
// Self-checking response sink: random back-pressure, per-tag in-order matching
// against an expected table, sticky first-error capture.
module vc_test_rand_delay_ooo_tag_sink #(
  parameter int unsigned p_msg_nbits   = 32,
  parameter int unsigned p_num_entries = 64,
  parameter int unsigned p_tag_nbits   = 4,
  parameter int unsigned p_tag_offset  = 0,
  parameter int unsigned p_max_delay   = 0,
  parameter logic [15:0] p_seed        = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_en,
  input  logic [$clog2(p_num_entries)-1:0]      cfg_idx,
  input  logic [p_msg_nbits-1:0]                cfg_msg,
  input  logic                                  cfg_num_en,
  input  logic [$clog2(p_num_entries+1)-1:0]    cfg_num,
  vc_test_rand_delay_ooo_tag_sink_if.slave      recv,
  output logic                                  done,
  output logic                                  err,
  output logic [1:0]                            err_code,
  output logic [p_msg_nbits-1:0]                err_msg,
  output logic [$clog2(p_num_entries+1)-1:0]    num_recv
);

  localparam int unsigned IDX_W     = $clog2(p_num_entries);
  localparam int unsigned CNT_W     = $clog2(p_num_entries + 1);
  localparam int unsigned DLY_W     = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam logic [15:0] SEED      = (p_seed == 16'h0) ? 16'h1 : p_seed;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DLY_MOD   = 16'(p_max_delay + 1);

  localparam logic [1:0] CODE_NO_TAG   = 2'b01;
  localparam logic [1:0] CODE_MISMATCH = 2'b10;
  localparam logic [1:0] CODE_EXTRA    = 2'b11;

  typedef enum logic {S_DELAY, S_READY} state_e;

  state_e                 state_q, state_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   rdy_q, rdy_d;
  logic [CNT_W-1:0]       exp_num_q, exp_num_d;
  logic [CNT_W-1:0]       recv_q, recv_d;
  logic [CNT_W-1:0]       mcnt_q, mcnt_d;
  logic [p_num_entries-1:0] match_q, match_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic [p_msg_nbits-1:0] emsg_q, emsg_d;
  logic                   done_q, done_d;
  logic [1:0]             hs_code;

  logic [p_msg_nbits-1:0] table_q [p_num_entries];

  logic                   hs;
  logic [p_tag_nbits-1:0] msg_tag;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;

  assign hs      = recv.val && rdy_q;
  assign msg_tag = recv.msg[p_tag_offset +: p_tag_nbits];

  // Expected table is payload only; it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (cfg_en) table_q[cfg_idx] <= cfg_msg;
  end

  // Lowest-index unmatched live entry carrying the incoming tag.
  always_comb begin : tag_search
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = p_num_entries - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < exp_num_q) && !match_q[i] &&
          (table_q[i][p_tag_offset +: p_tag_nbits] == msg_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    dly_d     = dly_q;
    lfsr_d    = lfsr_q;
    exp_num_d = exp_num_q;
    recv_d    = recv_q;
    mcnt_d    = mcnt_q;
    match_d   = match_q;
    err_d     = err_q;
    code_d    = code_q;
    emsg_d    = emsg_q;
    hs_code   = 2'b00;

    case (state_q)
      S_DELAY: begin
        if (dly_q == '0) state_d = S_READY;
        else             dly_d   = dly_q - DLY_W'(1);
      end
      S_READY: begin
        if (hs) begin
          state_d = S_DELAY;
          dly_d   = DLY_W'(lfsr_q % DLY_MOD);
          lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
        end
      end
      default: state_d = S_DELAY;
    endcase

    if (hs) begin
      if (recv_q != '1) recv_d = recv_q + CNT_W'(1);
      if (recv_q >= exp_num_q)             hs_code = CODE_EXTRA;
      else if (!hit)                       hs_code = CODE_NO_TAG;
      else if (table_q[hit_idx] != recv.msg) hs_code = CODE_MISMATCH;
      else begin
        match_d[hit_idx] = 1'b1;
        mcnt_d           = mcnt_q + CNT_W'(1);
      end
      if ((hs_code != 2'b00) && !err_q) begin
        err_d  = 1'b1;
        code_d = hs_code;
        emsg_d = recv.msg;
      end
    end

    // Rewriting an entry re-arms it; a same-cycle match on it is discarded.
    if (cfg_en && match_d[cfg_idx]) begin
      match_d[cfg_idx] = 1'b0;
      mcnt_d           = mcnt_d - CNT_W'(1);
    end

    if (cfg_num_en) exp_num_d = cfg_num;

    rdy_d  = (state_d == S_READY);
    done_d = !err_d && (mcnt_d == exp_num_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_DELAY;
      dly_q     <= '0;
      lfsr_q    <= SEED;
      rdy_q     <= 1'b0;
      exp_num_q <= '0;
      recv_q    <= '0;
      mcnt_q    <= '0;
      match_q   <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      emsg_q    <= '0;
      done_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      lfsr_q    <= lfsr_d;
      rdy_q     <= rdy_d;
      exp_num_q <= exp_num_d;
      recv_q    <= recv_d;
      mcnt_q    <= mcnt_d;
      match_q   <= match_d;
      err_q     <= err_d;
      code_q    <= code_d;
      emsg_q    <= emsg_d;
      done_q    <= done_d;
    end
  end

  assign recv.rdy = rdy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign err_msg  = emsg_q;
  assign num_recv = recv_q;

endmodule
